// File: rtl/counters_pkg.sv
// Shared definitions for the LFSR counter family: FSM states, standard tap
// masks and a width-generic reference next-state function.
package counters_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEARCH = 2'd1,
      DONE   = 2'd2
   } state_e;

   localparam logic [15:0] LFSR_TAPS_16 = 16'hD008;
   localparam logic [31:0] LFSR_TAPS_32 = 32'h80200003;

   // XNOR LFSR step on the low 'width' bits (width 1..32); upper bits are returned as zero.
   function automatic logic [31:0] lfsr_next(input logic [31:0] state,
                                             input logic [31:0] taps,
                                             input int unsigned width);
      logic [31:0] mask;
      logic        fb;
      mask      = (width >= 32) ? 32'hFFFF_FFFF : ((32'h1 << width) - 32'h1);
      fb        = ~^(state & taps & mask);
      lfsr_next = ((state << 1) | {31'h0, fb}) & mask;
   endfunction

endpackage

// File: rtl/lfsr_step.sv
// Combinational single step of an XNOR LFSR; shared with lfsr_counter.
module lfsr_step
   import counters_pkg::*;
#(
   parameter int unsigned       WIDTH = 16,
   parameter logic [WIDTH-1:0]  TAPS  = LFSR_TAPS_16
) (
   input  logic [WIDTH-1:0] i_lfsr,
   output logic [WIDTH-1:0] o_nxt
);

   assign o_nxt = {i_lfsr[WIDTH-2:0], ~^(i_lfsr & TAPS)};

endmodule

// File: rtl/lfsr_index_decoder.sv
// Decodes an XNOR-LFSR state to its step index from seed 0 by stepping a
// reference LFSR until it matches the registered target.
module lfsr_index_decoder
   import counters_pkg::*;
#(
   parameter int unsigned       WIDTH = 16,
   parameter logic [WIDTH-1:0]  TAPS  = LFSR_TAPS_16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_lfsr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_index,
   output logic             out_err
);

   localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
   // Last index of the period (P-1 = 2^WIDTH-2); the counter never goes past it.
   localparam logic [WIDTH-1:0] CNT_LAST = {{(WIDTH-1){1'b1}}, 1'b0};

   state_e           r_state;
   logic [WIDTH-1:0] r_lfsr;
   logic [WIDTH-1:0] r_cnt;
   logic [WIDTH-1:0] r_target;
   logic [WIDTH-1:0] r_index;
   logic             r_err;
   logic             r_in_ready;
   logic             r_out_valid;

   logic [WIDTH-1:0] w_nxt;
   logic             w_hit;
   logic             w_last;

   lfsr_step #(
      .WIDTH (WIDTH),
      .TAPS  (TAPS)
   ) u_step (
      .i_lfsr (r_lfsr),
      .o_nxt  (w_nxt)
   );

   assign w_hit  = (r_lfsr == r_target);
   assign w_last = (r_cnt == CNT_LAST);

   // Search FSM and datapath; handshake flags are registered alongside the state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= IDLE;
         r_lfsr      <= ZERO;
         r_cnt       <= ZERO;
         r_target    <= ZERO;
         r_index     <= ZERO;
         r_err       <= 1'b0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid && r_in_ready) begin
                  r_target   <= in_lfsr;
                  r_lfsr     <= ZERO;
                  r_cnt      <= ZERO;
                  r_in_ready <= 1'b0;
                  // The all-ones lockup state is never reached from seed 0.
                  if (in_lfsr == ALL_ONES) begin
                     r_err       <= 1'b1;
                     r_index     <= ALL_ONES;
                     r_out_valid <= 1'b1;
                     r_state     <= DONE;
                  end else begin
                     r_state <= SEARCH;
                  end
               end
            end
            SEARCH: begin
               if (w_hit) begin
                  r_index     <= r_cnt;
                  r_err       <= 1'b0;
                  r_out_valid <= 1'b1;
                  r_state     <= DONE;
               end else if (w_last) begin
                  r_index     <= ALL_ONES;
                  r_err       <= 1'b1;
                  r_out_valid <= 1'b1;
                  r_state     <= DONE;
               end else begin
                  r_lfsr <= w_nxt;
                  r_cnt  <= r_cnt + ONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= IDLE;
               end
            end
            default: begin
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
               r_state     <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_index = r_index;
   assign out_err   = r_err;

endmodule

// File: tb/tb_lfsr_index_decoder.sv
// Directed bench for lfsr_index_decoder at WIDTH=4, TAPS=4'b1100.
module tb_lfsr_index_decoder;
   import counters_pkg::*;

   logic       clk;
   logic       reset;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_lfsr;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_index;
   logic       out_err;

   int checks = 0;
   int errors = 0;
   int edges;

   lfsr_index_decoder #(
      .WIDTH (4),
      .TAPS  (4'b1100)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_lfsr   (in_lfsr),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_index (out_index),
      .out_err   (out_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout simulation did not complete");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present a request at a falling edge, then count edges until out_valid (bounded).
   task automatic send(input logic [3:0] v, output int n);
      @(negedge clk);
      in_valid = 1'b1;
      in_lfsr  = v;
      @(posedge clk);
      n = 1;
      @(negedge clk);
      in_valid = 1'b0;
      in_lfsr  = ~v;
      while (out_valid !== 1'b1 && n < 40) begin
         @(posedge clk);
         n++;
         @(negedge clk);
      end
   endtask

   // With out_ready high, the next edge retires the result and in_ready returns.
   task automatic retire(input string tag);
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk({tag, "_valid_drop"}, {31'h0, out_valid}, 32'h0);
      chk({tag, "_ready_back"}, {31'h0, in_ready}, 32'h1);
   endtask

   initial begin
      logic [31:0] m;
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_lfsr   = 4'h0;
      out_ready = 1'b0;
      #12;
      chk("rst_in_ready",  {31'h0, in_ready},  32'h1);
      chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
      chk("rst_out_index", {28'h0, out_index}, 32'h0);
      chk("rst_out_err",   {31'h0, out_err},   32'h0);
      @(negedge clk);
      reset = 1'b0;

      // 1: seed itself
      send(4'h0, edges);
      chk("t1_lat",   32'(edges), 32'd2);
      chk("t1_index", {28'h0, out_index}, 32'h0);
      chk("t1_err",   {31'h0, out_err}, 32'h0);
      retire("t1");

      // 2: mid-sequence states
      send(4'h7, edges);
      chk("t2a_index", {28'h0, out_index}, 32'd3);
      chk("t2a_lat",   32'(edges), 32'd5);
      retire("t2a");
      send(4'hB, edges);
      chk("t2b_index", {28'h0, out_index}, 32'd6);
      retire("t2b");

      // 3: worst case
      send(4'h8, edges);
      chk("t3_index", {28'h0, out_index}, 32'd14);
      chk("t3_lat",   32'(edges), 32'd16);
      chk("t3_err",   {31'h0, out_err}, 32'h0);
      retire("t3");

      // 4: lockup state
      send(4'hF, edges);
      chk("t4_lat",   32'(edges), 32'd1);
      chk("t4_index", {28'h0, out_index}, 32'hF);
      chk("t4_err",   {31'h0, out_err}, 32'h1);
      retire("t4");
      out_ready = 1'b0;

      // 5: held result while in_valid pulses are ignored
      send(4'hB, edges);
      for (int i = 0; i < 10; i++) begin
         in_valid = i[0];
         in_lfsr  = 4'h0;
         @(posedge clk);
         @(negedge clk);
         chk("t5_valid",    {31'h0, out_valid}, 32'h1);
         chk("t5_index",    {28'h0, out_index}, 32'd6);
         chk("t5_err",      {31'h0, out_err},   32'h0);
         chk("t5_in_ready", {31'h0, in_ready},  32'h0);
      end
      in_valid = 1'b0;
      retire("t5");
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("t5_no_new_req", {31'h0, out_valid}, 32'h0);
      chk("t5_idle_ready", {31'h0, in_ready},  32'h1);

      // 6: asynchronous reset mid-search, then a fresh request
      @(negedge clk);
      in_valid = 1'b1;
      in_lfsr  = 4'h8;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      chk("t6_busy", {31'h0, in_ready}, 32'h0);
      #2;
      reset = 1'b1;
      #1;
      chk("t6_in_ready",  {31'h0, in_ready},  32'h1);
      chk("t6_out_valid", {31'h0, out_valid}, 32'h0);
      chk("t6_out_index", {28'h0, out_index}, 32'h0);
      chk("t6_out_err",   {31'h0, out_err},   32'h0);
      @(negedge clk);
      reset = 1'b0;
      send(4'h3, edges);
      chk("t6_index", {28'h0, out_index}, 32'd2);
      retire("t6");

      // Scoreboard: every index back to back with out_ready held high
      m = 32'h0;
      for (int k = 0; k < 15; k++) begin
         send(m[3:0], edges);
         chk("sb_index", {28'h0, out_index}, 32'(k));
         chk("sb_err",   {31'h0, out_err},   32'h0);
         chk("sb_lat",   32'(edges), 32'(k + 2));
         retire("sb");
         m = lfsr_next(m, 32'h0000_000C, 4);
      end
      chk("sb_period", m, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
